// File: rtl/sm_trace_buffer.sv
// rtl/sm_trace_buffer.sv - schoolMIPS instruction-trace capture buffer
// Circular PC/instruction/cycle capture with programmable trigger and post-trigger window.
module sm_trace_buffer #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH_LOG2  = 5,
  parameter int CYCLE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_valid,
  input  logic [PC_WIDTH-1:0]    cpu_pc,
  input  logic [INSTR_WIDTH-1:0] cpu_instr,
  input  logic                   arm,
  input  logic [1:0]             trig_mode,
  input  logic [PC_WIDTH-1:0]    trig_pc,
  input  logic [INSTR_WIDTH-1:0] trig_instr,
  input  logic [INSTR_WIDTH-1:0] trig_mask,
  input  logic [DEPTH_LOG2-1:0]  post_count,
  input  logic [CYCLE_WIDTH-1:0] timeout,
  input  logic [DEPTH_LOG2-1:0]  rd_addr,
  output logic [PC_WIDTH-1:0]    rd_pc,
  output logic [INSTR_WIDTH-1:0] rd_instr,
  output logic [CYCLE_WIDTH-1:0] rd_cycle,
  output logic [1:0]             state,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   triggered,
  output logic [CYCLE_WIDTH-1:0] trig_cycle
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'b00, PRE = 2'b01, POST = 2'b10, DONE = 2'b11} stateT;
  stateT stateQ, stateD;

  logic [DEPTH_LOG2-1:0]  wrPtr, postRem, rdPhys;
  logic [DEPTH_LOG2:0]    countQ;
  logic [CYCLE_WIDTH-1:0] cycleQ, trigCycleQ;
  logic                   trigQ, capture, trigCond, hit;

  logic [PC_WIDTH-1:0]    pcMem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instrMem [DEPTH];
  logic [CYCLE_WIDTH-1:0] cycleMem [DEPTH];

  always_comb begin
    trigCond = 1'b0;
    case (trig_mode)
      2'b00: trigCond = 1'b1;
      2'b01: trigCond = (cpu_pc == trig_pc);
      2'b10: trigCond = ((cpu_instr & trig_mask) == (trig_instr & trig_mask));
      default: trigCond = (cycleQ == timeout);
    endcase
  end

  // arm suppresses capture in its own cycle
  assign capture = cpu_valid && !arm && (stateQ == PRE || stateQ == POST);
  assign hit     = capture && (stateQ == PRE) && trigCond;

  always_comb begin
    stateD = stateQ;
    if (arm) begin
      stateD = PRE;
    end else begin
      case (stateQ)
        PRE:  if (hit) stateD = (post_count == '0) ? DONE : POST;
        POST: if (capture && postRem == DEPTH_LOG2'(1)) stateD = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      wrPtr      <= '0;
      countQ     <= '0;
      cycleQ     <= '0;
      trigQ      <= 1'b0;
      trigCycleQ <= '0;
      postRem    <= '0;
    end else if (capture) begin
      wrPtr <= wrPtr + DEPTH_LOG2'(1);
      if (countQ != (DEPTH_LOG2+1)'(DEPTH)) countQ <= countQ + (DEPTH_LOG2+1)'(1);
      if (cycleQ != '1) cycleQ <= cycleQ + CYCLE_WIDTH'(1);
      if (hit) begin
        trigQ      <= 1'b1;
        trigCycleQ <= cycleQ;
        // post_count is DEPTH_LOG2 bits wide, so it never exceeds DEPTH-1
        postRem    <= post_count;
      end else if (stateQ == POST) begin
        postRem <= postRem - DEPTH_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pcMem[wrPtr]    <= cpu_pc;
      instrMem[wrPtr] <= cpu_instr;
      cycleMem[wrPtr] <= cycleQ;
    end
  end

  // when count == DEPTH its low bits are zero, so oldest entry is wrPtr itself
  assign rdPhys = wrPtr - countQ[DEPTH_LOG2-1:0] + rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pc    <= '0;
      rd_instr <= '0;
      rd_cycle <= '0;
    end else begin
      rd_pc    <= pcMem[rdPhys];
      rd_instr <= instrMem[rdPhys];
      rd_cycle <= cycleMem[rdPhys];
    end
  end

  assign state      = stateQ;
  assign count      = countQ;
  assign triggered  = trigQ;
  assign trig_cycle = trigCycleQ;
endmodule

// File: doc/sm_trace_buffer.md
# sm_trace_buffer

Synthesizable instruction-trace capture block for the schoolMIPS core, the in-hardware successor to the simulation-only per-cycle trace and timeout printout. It samples the retiring PC and instruction word on every enabled CPU cycle into a circular buffer and stops on a programmable trigger. Supported triggers are immediate, PC match, masked instruction match, or cycle-count timeout. The captured pre-trigger and post-trigger window can then be read back by debug logic or by a bench, one entry per address.

## Interface
- PC_WIDTH, 32, width of captured PC
- INSTR_WIDTH, 32, width of captured instruction word
- DEPTH_LOG2, 5, buffer depth = 2**DEPTH_LOG2 entries
- CYCLE_WIDTH, 16, width of capture cycle counter

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_valid  in  1  CPU cycle enable; capture and trigger evaluation only when high
- cpu_pc  in  PC_WIDTH  current PC
- cpu_instr  in  INSTR_WIDTH  current instruction
- arm  in  1  single-cycle pulse: clear buffer and start capture
- trig_mode  in  2  00 immediate, 01 PC match, 10 masked instr match, 11 timeout
- trig_pc  in  PC_WIDTH  PC compare value
- trig_instr  in  INSTR_WIDTH  instruction compare value
- trig_mask  in  INSTR_WIDTH  1 = bit participates in instr compare
- post_count  in  DEPTH_LOG2  entries to capture after the trigger entry
- timeout  in  CYCLE_WIDTH  cycle index at which timeout mode triggers
- rd_addr  in  DEPTH_LOG2  read index, 0 = oldest valid entry
- rd_pc  out  PC_WIDTH  entry PC, registered
- rd_instr  out  INSTR_WIDTH  entry instruction, registered
- rd_cycle  out  CYCLE_WIDTH  entry cycle index, registered
- state  out  2  00 IDLE, 01 PRE, 10 POST, 11 DONE
- count  out  DEPTH_LOG2+1  number of valid entries, 0..DEPTH
- triggered  out  1  trigger has fired since last arm
- trig_cycle  out  CYCLE_WIDTH  cycle index of trigger entry

## Operation
- The cycle counter clears on arm and increments on each cpu_valid cycle while in PRE or POST. It saturates at all-ones. Its pre-increment value is stored as the entry's cycle index, so the first entry after arm has index 0.
- Entry = {cpu_pc, cpu_instr, cycle}, written at wr_ptr on each cpu_valid cycle in PRE or POST. wr_ptr wraps modulo DEPTH. count increments and saturates at DEPTH; once saturated, the oldest entry is overwritten.
- IDLE: no capture. arm -> PRE.
- PRE: capture. The trigger is evaluated on the entry being written:
  - 00: always true.
  - 01: cpu_pc == trig_pc.
  - 10: (cpu_instr & trig_mask) == (trig_instr & trig_mask).
  - 11: cycle == timeout.
- On a hit: the entry is written, triggered=1, trig_cycle=cycle, and post_remaining is loaded with min(post_count, DEPTH-1). The next state is POST, or DONE if post_remaining is 0.
- POST: capture. Each write decrements post_remaining. The write that takes it to 0 moves the state to DONE.
- DONE: no capture, buffer frozen. arm -> PRE.
- arm in any state restarts the capture:
  - count, wr_ptr, cycle counter, triggered and trig_cycle are cleared.
  - The next state is PRE.
  - No capture occurs in the arm cycle itself, even when cpu_valid is high.
- Readout:
  - Physical address = (wr_ptr - count + rd_addr) mod DEPTH.
  - Reads are legal in any state.
  - rd_addr >= count returns stale or undefined data; this is not checked.
- trig_mode, trig_pc, trig_instr, trig_mask, post_count and timeout are sampled live and must be held stable from arm to DONE.

## Timing
- All outputs are registered. Reset values: state=IDLE, count=0, triggered=0, trig_cycle=0, rd_pc=0, rd_instr=0, rd_cycle=0, wr_ptr=0.
- The buffer RAM contents are not reset.
- Read latency is 1 cycle: rd_addr presented at edge N gives rd_* valid after edge N+1.
- Capture, state, count and triggered all update on the same edge as the write.
- Reading the same entry that is being written in the same cycle returns the old contents.
- rst has priority over arm; arm has priority over capture.
- rst mid-capture returns the block to IDLE next edge with all outputs at reset values.
- A trigger hit and the final post write never coincide. POST is entered only on the edge after the trigger entry is written.
- In timeout mode, the trigger cannot fire if timeout exceeds the saturated counter value. The capture then remains in PRE until re-armed.

## Test plan
Bench uses DEPTH_LOG2=3 (depth 8).
- Immediate trigger:
  - Stimulus: trig_mode=00, post_count=3, arm, then 4 valid cycles with pc=0,1,2,3.
  - Response: DONE after the 4th edge, count=4, trig_cycle=0, rd_addr 0..3 -> pc 0..3, cycle 0..3.
- PC match with wrap:
  - Stimulus: trig_mode=01, trig_pc=20, post_count=2, feed pc=0..30.
  - Response: DONE after the pc=22 write, count=8, rd_addr 0 -> pc 15, rd_addr 5 -> pc 20, rd_addr 7 -> pc 22, trig_cycle=20, later pcs not captured.
- Masked instruction match:
  - Stimulus: mask=0xFC000000, trig_instr=0x14000000, stream 0x24020001, 0x00000000, 0x1443FFFE, 0x00000000, post_count=1.
  - Response: triggered on 0x1443FFFE (trig_cycle=2), DONE with count=4.
- Timeout with gaps:
  - Stimulus: trig_mode=11, timeout=10, post_count=0, cpu_valid toggling 1,0,1,0...
  - Response: trigger on the 11th valid cycle (cycle=10, 21st clock after arm), DONE on the same edge, count=8, oldest rd_cycle=3.
- Clamp, re-arm and reset:
  - post_count=7 clamps to 7 post entries.
  - arm during POST: count=0, triggered=0, state=PRE next edge; the arm-cycle cpu_valid is not captured.
  - rst asserted during PRE: all outputs return to reset values next edge.
